// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus for regfile_wb_arbiter.
// Purpose: bundles the two result handshakes (ALU port A, LSU port B),
//   the registered regfile write port, the two forward query ports and idle.
// Ports (signals):
//   a_valid/a_ready/a_rd/a_data   ALU result handshake
//   b_valid/b_ready/b_rd/b_data   LSU result handshake
//   wen/waddr/wdata               regfile write port (registered)
//   qN_addr/qN_hit/qN_data        forward queries, N = 1,2
//   idle                          nothing pending anywhere
// Modports: master = result producers / decode side, slave = the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic            a_valid;
  logic            a_ready;
  logic [AW-1:0]   a_rd;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [AW-1:0]   b_rd;
  logic [XLEN-1:0] b_data;
  logic            wen;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic [AW-1:0]   q1_addr;
  logic            q1_hit;
  logic [XLEN-1:0] q1_data;
  logic [AW-1:0]   q2_addr;
  logic            q2_hit;
  logic [XLEN-1:0] q2_data;
  logic            idle;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data, q1_addr, q2_addr,
    input  a_ready, b_ready, wen, waddr, wdata, q1_hit, q1_data, q2_hit, q2_data, idle
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, q1_addr, q2_addr,
    output a_ready, b_ready, wen, waddr, wdata, q1_hit, q1_data, q2_hit, q2_data, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Purpose: write-back side of the integer register file. ALU (A) and LSU (B)
//   results are captured in one-entry holding buffers, arbitrated oldest-first
//   and written through a registered single write port. Pending values are
//   forwarded to two query ports so decode never sees a stale register.
// Ports:
//   clk   single clock, all state on posedge
//   rst   synchronous reset, active-high
//   bus   regfile_wb_arbiter_if.slave (handshakes, write port, queries, idle)
module regfile_wb_arbiter #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input logic                  clk,
  input logic                  rst,
  regfile_wb_arbiter_if.slave  bus
);

  typedef struct packed {
    logic            v;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } hold_t;

  hold_t           ha;
  hold_t           hb;
  logic            b_older;
  logic            grant_a;
  logic            grant_b;
  logic            load_a;
  logic            load_b;
  logic            wen_q;
  logic [AW-1:0]   waddr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN:0]   fwd1;
  logic [XLEN:0]   fwd2;

  // Forward lookup returning {hit, data}. When both buffers match, the
  // younger one wins; the output stage is older than anything still buffered.
  function automatic logic [XLEN:0] fwd(
    input logic [AW-1:0]   addr,
    input hold_t           a,
    input hold_t           b,
    input logic            bold,
    input logic            w,
    input logic [AW-1:0]   wa,
    input logic [XLEN-1:0] wd
  );
    logic a_hit;
    logic b_hit;
    a_hit = a.v && (a.rd == addr);
    b_hit = b.v && (b.rd == addr);
    fwd   = '0;
    if (addr != '0) begin
      if (a_hit && b_hit)        fwd = {1'b1, bold ? a.data : b.data};
      else if (a_hit)            fwd = {1'b1, a.data};
      else if (b_hit)            fwd = {1'b1, b.data};
      else if (w && (wa == addr)) fwd = {1'b1, wd};
    end
  endfunction

  always_comb begin
    grant_a = ha.v && (!hb.v || !b_older);
    grant_b = hb.v && (!ha.v || b_older);
  end

  // A granted buffer drains this cycle, so it can take a new result at once.
  assign bus.a_ready = !rst && (!ha.v || grant_a);
  assign bus.b_ready = !rst && (!hb.v || grant_b);

  // Results for x0 complete the handshake but are never stored.
  assign load_a = bus.a_valid && bus.a_ready && (bus.a_rd != '0);
  assign load_b = bus.b_valid && bus.b_ready && (bus.b_rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ha      <= '0;
      hb      <= '0;
      b_older <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      if (load_a)       ha   <= {1'b1, bus.a_rd, bus.a_data};
      else if (grant_a) ha.v <= 1'b0;

      if (load_b)       hb   <= {1'b1, bus.b_rd, bus.b_data};
      else if (grant_b) hb.v <= 1'b0;

      // The buffer that stays put is older than one that loads; a tie
      // (both loading together) is resolved in favour of B.
      if (load_a && (load_b || (hb.v && !grant_b)))
        b_older <= 1'b1;
      else if (load_b && ha.v && !grant_a)
        b_older <= 1'b0;

      wen_q <= grant_a || grant_b;
      if (grant_a) begin
        waddr_q <= ha.rd;
        wdata_q <= ha.data;
      end else if (grant_b) begin
        waddr_q <= hb.rd;
        wdata_q <= hb.data;
      end
    end
  end

  always_comb begin
    fwd1 = fwd(bus.q1_addr, ha, hb, b_older, wen_q, waddr_q, wdata_q);
    fwd2 = fwd(bus.q2_addr, ha, hb, b_older, wen_q, waddr_q, wdata_q);
  end

  assign bus.q1_hit  = fwd1[XLEN];
  assign bus.q1_data = fwd1[XLEN-1:0];
  assign bus.q2_hit  = fwd2[XLEN];
  assign bus.q2_data = fwd2[XLEN-1:0];

  assign bus.wen   = wen_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;
  assign bus.idle  = !ha.v && !hb.v && !wen_q;

endmodule
